sig_fp2fix_buf: RTL and testbench
=================================

// Module: sig_fp2fix_buf
// PURPOSE
//  Downstream stage of the sigmoid unit. Consumes the IEEE-754 single y_out/valid stream and converts each result (nominally in [0,1]) to unsigned fixed point Q0.FRAC with round-half-up and saturation.
//  Buffers codes in a FIFO toward a ready/valid consumer. The sigmoid side has no backpressure, so FIFO overflow drops data and raises a sticky flag.
// PARAMETERS
//  DWIDTH          32   float word width
//  EXPONENT_WIDTH  8    float exponent width
//  BIAS            127  exponent bias
//  FRAC            16   output fraction bits, 1..23
//  DEPTH           8    FIFO entries, power of 2, >=2
//  AW              3    log2(DEPTH)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         synchronous reset, active-high
//  valid_in   in   1         connects to sigmoid valid; y_in is sampled when high
//  y_in       in   DWIDTH    connects to sigmoid y_out
//  m_data     out  FRAC      fixed-point code at FIFO head
//  m_valid    out  1         FIFO not empty
//  m_ready    in   1         consumer pops when m_valid & m_ready
//  count      out  AW+1      FIFO occupancy, 0..DEPTH
//  ovf        out  1         sticky: a code was dropped because FIFO full
//  err_nan    out  1         sticky: a NaN was received
//  sat_count  out  16        saturated-conversion counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: on the edge with rst=1, pipeline valids, FIFO pointers, count, ovf, err_nan and sat_count all go to 0. m_valid=0, m_data=0. Data in flight is discarded. Reset overrides everything.
//  Pipeline:
//   - S1 (edge T0): register sign, class and shift amount sh = BIAS+23-FRAC-e.
//   - S2 (edge T0+1): shift and round, producing the code.
//   - FIFO write at edge T0+2; m_valid high from T0+2 if the FIFO was empty.
//   - Throughput 1 sample/cycle; no stalls.
//  Conversion, with e = exponent, S = {1,mantissa} (24b):
//   - e=all-ones, mant!=0 (NaN): code 0; set err_nan.
//   - sign=1 (negatives, -0, -inf): code 0.
//   - e=0 (zero or denormal): code 0.
//   - e>=BIAS (>=1.0, +inf): code 2^FRAC-1 (saturated).
//   - else if sh>=25: code 0.
//   - else: code = (S>>sh) + S[sh-1] (round half up).
//   - If the rounded result equals 2^FRAC: code 2^FRAC-1 (saturated).
//  FIFO:
//   - First-word-fall-through; m_data is valid whenever m_valid=1.
//   - push when the S2 valid is high; pop when m_valid & m_ready.
//   - Full with no pop: push dropped, ovf<=1.
//   - Full with pop: both occur, count unchanged.
//   - Empty: pop impossible (m_valid=0); a push alone makes m_valid high next cycle.
//   - Pointers wrap modulo DEPTH. count tracks pushes minus pops.
//   - m_data is don't-care when m_valid=0.
//  ovf and err_nan clear only on rst.
// CONFIGURATION
//  SIG_FIX_STATS_EN defined:
//   - sat_count increments on each code that takes either saturated path above (e>=BIAS/+inf, or rounding overflow to 2^FRAC).
//   - It counts at S2, including codes later dropped by overflow.
//   - Saturates at 0xFFFF; reset to 0.
//  SIG_FIX_STATS_EN undefined: counter logic absent; sat_count tied to 0.
// TESTING
//  1 0x3F000000 (0.5) -> code 0x8000 at T0+2; then 0x3F400000 (0.75) -> 0xC000, with m_ready=1.
//  2 Boundaries, in order:
//     0x3F800000 -> 0xFFFF
//     0x3F7FFFFF -> 0xFFFF (round overflow)
//     0x7F800000 -> 0xFFFF
//     0x37000000 -> 0x0001
//     0x36800000 -> 0x0000
//     0xBF000000 -> 0x0000
//     0x00480000 -> 0x0000
//    With STATS_EN, sat_count=3 at the end.
//  3 0x7FC80000 (NaN) -> code 0, err_nan=1 and stays 1 until rst.
//  4 m_ready=0; 10 back-to-back valid_in -> first 8 codes stored, count=8, ovf=1. Then m_ready=1 -> 8 codes drain in order, m_valid falls after the 8th.
//  5 FIFO full plus push and pop in the same cycle -> count stays 8, ovf unchanged, order preserved.
//  6 rst=1 for one edge with 2 samples in the pipeline and 3 in the FIFO -> count=0, m_valid=0, ovf=0, and no code emitted afterwards.

Source files
------------

// File: rtl/sig_fp2fix_buf.sv
// sig_fp2fix_buf: float32 to unsigned Q0.FRAC converter with FWFT FIFO.
// Define SIG_FIX_STATS_EN to enable the saturation counter.
module sig_fp2fix_buf #(
  parameter int DWIDTH         = 32,
  parameter int EXPONENT_WIDTH = 8,
  parameter int BIAS           = 127,
  parameter int FRAC           = 16,
  parameter int DEPTH          = 8,
  parameter int AW             = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DWIDTH-1:0] y_in,
  output logic [FRAC-1:0]   m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [AW:0]       count,
  output logic              ovf,
  output logic              err_nan,
  output logic [15:0]       sat_count
);

  localparam int MW = DWIDTH - EXPONENT_WIDTH - 1;
  localparam int SW = $clog2(MW + 2);

  typedef enum logic [1:0] {
    C_ZERO,
    C_SAT,
    C_NORM
  } cls_t;

  logic                      sgn;
  logic [EXPONENT_WIDTH-1:0] exp_f;
  logic [MW-1:0]             man;
  logic                      is_nan;
  logic [31:0]               shw;
  cls_t                      cls_d;

  assign sgn    = y_in[DWIDTH-1];
  assign exp_f  = y_in[DWIDTH-2 -: EXPONENT_WIDTH];
  assign man    = y_in[MW-1:0];
  assign is_nan = (&exp_f) & (|man);
  assign shw    = 32'(BIAS + MW - FRAC) - 32'(exp_f);

  always_comb begin
    cls_d = C_NORM;
    if (is_nan || sgn || exp_f == '0)
      cls_d = C_ZERO;
    else if (32'(exp_f) >= 32'(BIAS))
      cls_d = C_SAT;
    else if (shw >= 32'(MW + 2))
      cls_d = C_ZERO;
  end

  logic          v1;
  logic          nan1;
  cls_t          cls1;
  logic [SW-1:0] sh1;
  logic [MW:0]   s1m;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      nan1 <= 1'b0;
      cls1 <= C_ZERO;
      sh1  <= '0;
      s1m  <= '0;
    end else begin
      v1   <= valid_in;
      nan1 <= valid_in & is_nan;
      cls1 <= cls_d;
      sh1  <= shw[SW-1:0];
      s1m  <= {1'b1, man};
    end
  end

  logic [MW:0]     shifted;
  logic            rbit;
  logic [MW+1:0]   sum;
  logic            ovr;
  logic [FRAC-1:0] code_d;

  // sh is at least 1 on the normal path, so sh-1 is a valid bit index
  assign shifted = s1m >> sh1;
  assign rbit    = s1m[sh1 - SW'(1)];
  assign sum     = {1'b0, shifted} + (MW + 2)'(rbit);
  assign ovr     = |sum[MW+1:FRAC];

  always_comb begin
    code_d = '0;
    unique case (cls1)
      C_SAT:   code_d = '1;
      C_NORM:  code_d = ovr ? '1 : sum[FRAC-1:0];
      default: code_d = '0;
    endcase
  end

  logic            v2;
  logic [FRAC-1:0] c2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2      <= 1'b0;
      c2      <= '0;
      err_nan <= 1'b0;
    end else begin
      v2 <= v1;
      c2 <= code_d;
      if (v1 && nan1)
        err_nan <= 1'b1;
    end
  end

`ifdef SIG_FIX_STATS_EN
  logic        sat_hit;
  logic [15:0] sat_q;

  assign sat_hit = v1 & ((cls1 == C_SAT) |
                         ((cls1 == C_NORM) & ovr));

  always_ff @(posedge clk) begin
    if (rst)
      sat_q <= '0;
    else if (sat_hit && sat_q != 16'hFFFF)
      sat_q <= sat_q + 16'd1;
  end

  assign sat_count = sat_q;
`else
  assign sat_count = '0;
`endif

  logic [FRAC-1:0] mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [AW:0]     cnt;
  logic            full;
  logic            pop;
  logic            wr;

  assign full    = (cnt == (AW + 1)'(DEPTH));
  assign m_valid = (cnt != '0);
  assign pop     = m_valid & m_ready;
  // a pop frees the slot, so a full FIFO still accepts the push
  assign wr      = v2 & (~full | pop);
  assign count   = cnt;
  assign m_data  = m_valid ? mem[rp] : '0;

  always_ff @(posedge clk) begin
    if (wr)
      mem[wp] <= c2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (wr)
        wp <= wp + AW'(1);
      if (pop)
        rp <= rp + AW'(1);
      if (wr && !pop)
        cnt <= cnt + (AW + 1)'(1);
      else if (!wr && pop)
        cnt <= cnt - (AW + 1)'(1);
      if (v2 && full && !pop)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sig_fp2fix_buf.sv
// tb_sig_fp2fix_buf: self-checking bench for sig_fp2fix_buf.
// Random and directed stimulus against a real-arithmetic reference model.
module tb_sig_fp2fix_buf;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [31:0] y_in;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  count;
  logic        ovf;
  logic        err_nan;
  logic [15:0] sat_count;

  int errs;
  int checks;

  bit          p1v;
  logic [31:0] p1y;
  bit          p2v;
  logic [15:0] p2c;
  logic [15:0] q[$];
  bit          movf;
  bit          mnan;
  int          msat;

  sig_fp2fix_buf dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .y_in      (y_in),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .count     (count),
    .ovf       (ovf),
    .err_nan   (err_nan),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit ref_isnan(logic [31:0] y);
    return (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
  endfunction

  function automatic real ref_scaled(logic [31:0] y);
    int e;
    real s;
    e = int'(y[30:23]);
    s = real'(int'(y[22:0]) + 8388608);
    return s * (2.0 ** real'(e - 150)) * 65536.0;
  endfunction

  function automatic logic [15:0] ref_code(logic [31:0] y);
    real c;
    if (ref_isnan(y) || y[31] || y[30:23] == 8'h00)
      return 16'h0000;
    if (y[30:23] == 8'hFF)
      return 16'hFFFF;
    c = $floor(ref_scaled(y) + 0.5);
    if (c >= 65536.0)
      return 16'hFFFF;
    return 16'($rtoi(c));
  endfunction

  function automatic bit ref_sat(logic [31:0] y);
    if (ref_isnan(y) || y[31] || y[30:23] == 8'h00)
      return 1'b0;
    if (y[30:23] == 8'hFF)
      return 1'b1;
    return $floor(ref_scaled(y) + 0.5) >= 65536.0;
  endfunction

  function automatic logic [31:0] rand_unit();
    return {1'b0, 8'($urandom_range(110, 126)),
            23'($urandom)};
  endfunction

  function automatic logic [31:0] rand_y();
    int k;
    k = $urandom_range(0, 7);
    if (k < 4)
      return rand_unit();
    if (k == 4)
      return {9'h07E, 15'h7FFF, 8'($urandom)};
    if (k == 5)
      return $urandom;
    if (k == 6)
      return {1'b0, 8'($urandom_range(127, 255)), 23'd0};
    return {1'b0, 8'($urandom_range(100, 112)),
            23'($urandom)};
  endfunction

  // advance one edge, updating the model from the inputs seen there
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      q.delete();
      p1v  = 0;
      p2v  = 0;
      movf = 0;
      mnan = 0;
      msat = 0;
    end else begin
      if (q.size() > 0 && m_ready)
        void'(q.pop_front());
      if (p2v) begin
        if (q.size() < DEPTH)
          q.push_back(p2c);
        else
          movf = 1;
      end
      if (p1v) begin
        if (ref_isnan(p1y))
          mnan = 1;
        if (ref_sat(p1y) && msat < 65535)
          msat++;
      end
      p2v = p1v;
      p2c = ref_code(p1y);
      p1v = valid_in;
      p1y = y_in;
    end
    #1;
  endtask

  task automatic do_rst();
    rst      = 1;
    valid_in = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst      = 1;
    valid_in = 0;
    y_in     = 0;
    m_ready  = 0;
    tick();
    tick();
    rst = 0;
    checks++;
    if (m_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_mvalid: got %b want 0", m_valid);
    end
    checks++;
    if (count !== 4'd0) begin
      errs++;
      $display("FAIL reset_count: got %0d want 0", count);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errs++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
    checks++;
    if (err_nan !== 1'b0) begin
      errs++;
      $display("FAIL reset_nan: got %b want 0", err_nan);
    end
    checks++;
    if (sat_count !== 16'd0) begin
      errs++;
      $display("FAIL reset_sat: got %h want 0", sat_count);
    end
    checks++;
    if (m_data !== 16'd0) begin
      errs++;
      $display("FAIL reset_mdata: got %h want 0", m_data);
    end
  endtask

  task automatic test_basic();
    m_ready  = 1;
    valid_in = 1;
    y_in     = 32'h3F000000;
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_t0: got %b want 0", m_valid);
    end
    y_in = 32'h3F400000;
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_t1: got %b want 0", m_valid);
    end
    valid_in = 0;
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h8000) begin
      errs++;
      $display("FAIL basic_half: got v=%b %h want v=1 8000",
               m_valid, m_data);
    end
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'hC000) begin
      errs++;
      $display("FAIL basic_3q: got v=%b %h want v=1 C000",
               m_valid, m_data);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_empty: got %b want 0", m_valid);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] vin [7];
    logic [15:0] exp_c [7];
    logic [15:0] got[$];
    vin   = '{32'h3F800000, 32'h3F7FFFFF, 32'h7F800000,
              32'h37000000, 32'h36800000, 32'hBF000000,
              32'h00480000};
    exp_c = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001,
              16'h0000, 16'h0000, 16'h0000};
    do_rst();
    m_ready = 1;
    for (int i = 0; i < 12; i++) begin
      valid_in = (i < 7);
      y_in     = (i < 7) ? vin[i] : 32'h0;
      tick();
      if (m_valid)
        got.push_back(m_data);
    end
    checks++;
    if (got.size() != 7) begin
      errs++;
      $display("FAIL bound_len: got %0d want 7", got.size());
    end
    for (int i = 0; i < 7; i++) begin
      if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_c[i]) begin
          errs++;
          $display("FAIL bound_%0d: got %h want %h",
                   i, got[i], exp_c[i]);
        end
      end
    end
    checks++;
`ifdef SIG_FIX_STATS_EN
    if (sat_count !== 16'd3) begin
      errs++;
      $display("FAIL bound_sat: got %0d want 3", sat_count);
    end
`else
    if (sat_count !== 16'd0) begin
      errs++;
      $display("FAIL bound_sat: got %0d want 0", sat_count);
    end
`endif
  endtask

  task automatic test_nan();
    m_ready  = 1;
    valid_in = 1;
    y_in     = 32'h7FC80000;
    tick();
    valid_in = 0;
    tick();
    checks++;
    if (err_nan !== 1'b1) begin
      errs++;
      $display("FAIL nan_flag: got %b want 1", err_nan);
    end
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h0000) begin
      errs++;
      $display("FAIL nan_code: got v=%b %h want v=1 0000",
               m_valid, m_data);
    end
    for (int i = 0; i < 20; i++) begin
      valid_in = 1;
      y_in     = rand_unit();
      tick();
    end
    valid_in = 0;
    for (int i = 0; i < 4; i++)
      tick();
    checks++;
    if (err_nan !== 1'b1) begin
      errs++;
      $display("FAIL nan_sticky: got %b want 1", err_nan);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_c[$];
    logic [31:0] y;
    do_rst();
    m_ready = 0;
    for (int i = 0; i < 10; i++) begin
      y        = rand_unit();
      valid_in = 1;
      y_in     = y;
      exp_c.push_back(ref_code(y));
      tick();
    end
    valid_in = 0;
    for (int i = 0; i < 3; i++)
      tick();
    checks++;
    if (count !== 4'd8 || ovf !== 1'b1) begin
      errs++;
      $display("FAIL ovf_full: got cnt=%0d ovf=%b want 8 1",
               count, ovf);
    end
    m_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_c[i]) begin
        errs++;
        $display("FAIL ovf_drain_%0d: got v=%b %h want v=1 %h",
                 i, m_valid, m_data, exp_c[i]);
      end
      tick();
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errs++;
      $display("FAIL ovf_empty: got %b want 0", m_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_c[$];
    logic [31:0] y;
    int pi;
    pi = 0;
    do_rst();
    for (int c = 0; c < 24; c++) begin
      m_ready = (c >= 10);
      if (c == 10) begin
        checks++;
        if (count !== 4'd8) begin
          errs++;
          $display("FAIL b2b_fill: got %0d want 8", count);
        end
      end
      if (c > 10 && c <= 16) begin
        checks++;
        if (count !== 4'd8) begin
          errs++;
          $display("FAIL b2b_cnt_%0d: got %0d want 8", c, count);
        end
      end
      if (c >= 10 && m_valid) begin
        checks++;
        if (m_data !== exp_c[pi]) begin
          errs++;
          $display("FAIL b2b_order_%0d: got %h want %h",
                   pi, m_data, exp_c[pi]);
        end
        pi++;
      end
      valid_in = (c < 14);
      if (c < 14) begin
        y    = rand_unit();
        y_in = y;
        exp_c.push_back(ref_code(y));
      end
      tick();
    end
    checks++;
    if (pi != 14 || m_valid !== 1'b0 || ovf !== 1'b0) begin
      errs++;
      $display("FAIL b2b_end: got n=%0d v=%b ovf=%b want 14 0 0",
               pi, m_valid, ovf);
    end
  endtask

  task automatic test_reset_flight();
    do_rst();
    m_ready = 0;
    for (int i = 0; i < 10; i++) begin
      valid_in = 1;
      y_in     = rand_unit();
      tick();
    end
    valid_in = 0;
    tick();
    tick();
    m_ready = 1;
    for (int i = 0; i < 5; i++)
      tick();
    m_ready  = 0;
    valid_in = 1;
    y_in     = 32'h3F000000;
    tick();
    tick();
    checks++;
    if (count !== 4'd3 || ovf !== 1'b1) begin
      errs++;
      $display("FAIL flush_pre: got cnt=%0d ovf=%b want 3 1",
               count, ovf);
    end
    valid_in = 0;
    rst      = 1;
    tick();
    rst = 0;
    checks++;
    if (count !== 4'd0 || m_valid !== 1'b0 || ovf !== 1'b0) begin
      errs++;
      $display("FAIL flush_post: got cnt=%0d v=%b ovf=%b want 0",
               count, m_valid, ovf);
    end
    m_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (m_valid !== 1'b0) begin
        errs++;
        $display("FAIL flush_quiet_%0d: got %b want 0",
                 i, m_valid);
      end
    end
  endtask

  task automatic test_random();
    do_rst();
    for (int c = 0; c < 400; c++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      y_in     = rand_y();
      m_ready  = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if (m_valid !== (q.size() != 0) ||
          count !== 4'(q.size())) begin
        errs++;
        $display("FAIL rnd_occ_%0d: got v=%b c=%0d want c=%0d",
                 c, m_valid, count, q.size());
      end
      if (q.size() != 0) begin
        checks++;
        if (m_data !== q[0]) begin
          errs++;
          $display("FAIL rnd_data_%0d: got %h want %h",
                   c, m_data, q[0]);
        end
      end
      checks++;
      if (ovf !== movf || err_nan !== mnan) begin
        errs++;
        $display("FAIL rnd_flags_%0d: got %b%b want %b%b",
                 c, ovf, err_nan, movf, mnan);
      end
    end
    valid_in = 0;
    tick();
    tick();
    checks++;
`ifdef SIG_FIX_STATS_EN
    if (sat_count !== 16'(msat)) begin
      errs++;
      $display("FAIL rnd_sat: got %0d want %0d", sat_count, msat);
    end
`else
    if (sat_count !== 16'd0) begin
      errs++;
      $display("FAIL rnd_sat: got %0d want 0", sat_count);
    end
`endif
  endtask

  initial begin
    errs     = 0;
    checks   = 0;
    rst      = 1;
    valid_in = 0;
    y_in     = 0;
    m_ready  = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_nan();
    test_overflow();
    test_back_to_back();
    test_reset_flight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
